// File: rtl/load_fetch_pkg.sv
// ============================================================================
//  Module      : load_fetch_pkg
//  Description : Shared types and constants for the data-side load sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_fetch_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_type_t;

  // Encoding 7 is not a distinct load; it behaves exactly like LW.
  localparam logic [2:0] LW_ALIAS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_t;

  localparam logic [3:0] LANE_ALL = 4'b1111;

  function automatic logic is_misaligned(input logic [2:0] i_type, input logic [1:0] i_offset);
    logic w_mis;
    w_mis = 1'b0;
    case (i_type)
      LH, LHU:      w_mis = i_offset[0];
      LW, LW_ALIAS: w_mis = (i_offset != 2'b00);
      default:      w_mis = 1'b0;
    endcase
    return w_mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
//  Module      : load_extract
//  Description : Selects and extends the addressed byte/halfword of a word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extract
  import load_fetch_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_type,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword loads reaching here are already aligned, so only offset[1] picks the lane.
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_result = i_word;
    case (i_type)
      LB:      o_result = {{24{w_byte[7]}}, w_byte};
      LBU:     o_result = {24'd0, w_byte};
      LH:      o_result = {{16{w_half[15]}}, w_half};
      LHU:     o_result = {16'd0, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_fetch_unit.sv
// ============================================================================
//  Module      : load_fetch_unit
//  Description : One-at-a-time load sequencer on an Avalon-style read bus.
//                Optional LOAD_FETCH_TIMEOUT_EN aborts reads stalled for
//                TIMEOUT_CYCLES waitrequest cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_fetch_unit
  import load_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic [3:0]  data_byteenable,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_byte_offset,
  output logic        resp_lwl,
  output logic        resp_merge,
  output logic        resp_addr_error
);

  fsm_state_t  r_state;
  logic [1:0]  r_offset;
  logic [2:0]  r_type;
  logic        r_data_read;
  logic [31:0] r_data_address;
  logic [3:0]  r_byteenable;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic [1:0]  r_resp_offset;
  logic        r_resp_lwl;
  logic        r_resp_merge;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_timeout;
  logic [31:0] w_extracted;

  assign req_ready    = (r_state == ST_IDLE) && !reset;
  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = is_misaligned(req_type, req_addr[1:0]);

  load_extract u_extract (
    .i_word   (data_readdata),
    .i_offset (r_offset),
    .i_type   (r_type),
    .o_result (w_extracted)
  );

`ifdef LOAD_FETCH_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [C_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_BUS && data_waitrequest) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign w_timeout = data_waitrequest && (r_stall_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_offset       <= 2'b00;
      r_type         <= 3'd0;
      r_data_read    <= 1'b0;
      r_data_address <= 32'd0;
      r_byteenable   <= 4'd0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 32'd0;
      r_resp_offset  <= 2'b00;
      r_resp_lwl     <= 1'b0;
      r_resp_merge   <= 1'b0;
      r_resp_err     <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_offset <= req_addr[1:0];
            r_type   <= req_type;
            if (w_misaligned) begin
              r_state       <= ST_RESP;
              r_resp_valid  <= 1'b1;
              r_resp_data   <= 32'd0;
              r_resp_offset <= req_addr[1:0];
              r_resp_lwl    <= 1'b0;
              r_resp_merge  <= 1'b0;
              r_resp_err    <= 1'b1;
            end else begin
              r_state        <= ST_BUS;
              r_data_read    <= 1'b1;
              r_data_address <= {req_addr[31:2], 2'b00};
              r_byteenable   <= LANE_ALL;
            end
          end
        end
        ST_BUS: begin
          if (!data_waitrequest) begin
            r_state       <= ST_RESP;
            r_data_read   <= 1'b0;
            r_byteenable  <= 4'd0;
            r_resp_valid  <= 1'b1;
            r_resp_data   <= w_extracted;
            r_resp_offset <= r_offset;
            r_resp_lwl    <= (r_type == LWL);
            r_resp_merge  <= (r_type == LWL) || (r_type == LWR);
            r_resp_err    <= 1'b0;
          end else if (w_timeout) begin
            r_state       <= ST_RESP;
            r_data_read   <= 1'b0;
            r_byteenable  <= 4'd0;
            r_resp_valid  <= 1'b1;
            r_resp_data   <= 32'd0;
            r_resp_offset <= r_offset;
            r_resp_lwl    <= 1'b0;
            r_resp_merge  <= 1'b0;
            r_resp_err    <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_read        = r_data_read;
  assign data_address     = r_data_address;
  assign data_byteenable  = r_byteenable;
  assign resp_valid       = r_resp_valid;
  assign resp_data        = r_resp_data;
  assign resp_byte_offset = r_resp_offset;
  assign resp_lwl         = r_resp_lwl;
  assign resp_merge       = r_resp_merge;
  assign resp_addr_error  = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_load_fetch_unit.sv
// ============================================================================
//  Module      : tb_load_fetch_unit
//  Description : Directed scoreboard bench for load_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_fetch_unit;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [31:0] data_address;
  logic        data_read;
  logic [3:0]  data_byteenable;
  logic        data_waitrequest;
  logic [31:0] data_readdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_byte_offset;
  logic        resp_lwl;
  logic        resp_merge;
  logic        resp_addr_error;

  always #5 clk = ~clk;

  load_fetch_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_type         (req_type),
    .data_address     (data_address),
    .data_read        (data_read),
    .data_byteenable  (data_byteenable),
    .data_waitrequest (data_waitrequest),
    .data_readdata    (data_readdata),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_byte_offset (resp_byte_offset),
    .resp_lwl         (resp_lwl),
    .resp_merge       (resp_merge),
    .resp_addr_error  (resp_addr_error)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic        lwl;
    logic        merge;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_byte_offset", {30'd0, resp_byte_offset}, {30'd0, e.off});
        chk("resp_lwl", {31'd0, resp_lwl}, {31'd0, e.lwl});
        chk("resp_merge", {31'd0, resp_merge}, {31'd0, e.merge});
        chk("resp_addr_error", {31'd0, resp_addr_error}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.at);
      end
    end
  end

  // lat counts clock edges from accept to the edge that samples resp_valid high;
  // the monitor sees it one half-cycle earlier, after edge accept+lat-1.
  task automatic load(input logic [31:0] addr, input logic [2:0] t, input int ws,
                      input logic [31:0] rd, input logic [31:0] exp_addr,
                      input logic [31:0] exp_data, input logic exp_lwl,
                      input logic exp_merge, input logic exp_err, input int lat);
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid        = 1'b1;
    req_addr         = addr;
    req_type         = t;
    data_readdata    = rd;
    data_waitrequest = (ws > 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.data  = exp_data;
    e.off   = addr[1:0];
    e.lwl   = exp_lwl;
    e.merge = exp_merge;
    e.err   = exp_err;
    e.at    = cyc + lat - 1;
    sb.push_back(e);
    if (!exp_err) begin
      for (int i = 0; i <= ws; i++) begin
        @(negedge clk);
        chk("data_read_busy", {31'd0, data_read}, 32'd1);
        chk("data_address", data_address, exp_addr);
        chk("data_byteenable", {28'd0, data_byteenable}, 32'h0000_000F);
        data_waitrequest = (i < ws);
      end
    end
    @(negedge clk);
    chk("data_read_done", {31'd0, data_read}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    req_valid        = 1'b0;
    req_addr         = 32'd0;
    req_type         = 3'd0;
    data_waitrequest = 1'b0;
    data_readdata    = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_data_read", {31'd0, data_read}, 32'd0);
    chk("rst_data_address", data_address, 32'd0);
    chk("rst_byteenable", {28'd0, data_byteenable}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_addr_error", {31'd0, resp_addr_error}, 32'd0);
    reset = 1'b0;

    //   addr          type  ws  readdata       bus addr       result        lwl  mrg  err  lat
    load(32'h0000_1003, 3'd0, 0, 32'h80FF_1234, 32'h0000_1000, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 2);
    load(32'h0000_2002, 3'd3, 3, 32'hBEEF_0000, 32'h0000_2000, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 5);
    load(32'h0000_3001, 3'd5, 0, 32'hAABB_CCDD, 32'h0000_3000, 32'hAABB_CCDD, 1'b1, 1'b1, 1'b0, 2);
    load(32'h0000_4002, 3'd4, 0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
    load(32'h0000_1000, 3'd2, 0, 32'h1234_8001, 32'h0000_1000, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0, 2);
    load(32'h0000_1002, 3'd2, 0, 32'h7FFF_0000, 32'h0000_1000, 32'h0000_7FFF, 1'b0, 1'b0, 1'b0, 2);
    load(32'h0000_1001, 3'd1, 0, 32'h0000_F500, 32'h0000_1000, 32'h0000_00F5, 1'b0, 1'b0, 1'b0, 2);
    load(32'h0000_4000, 3'd7, 0, 32'hCAFE_BABE, 32'h0000_4000, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0, 2);
    load(32'h0000_2001, 3'd3, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
    load(32'h0000_4003, 3'd7, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
    load(32'h0000_1000, 3'd0, 0, 32'h0000_007F, 32'h0000_1000, 32'h0000_007F, 1'b0, 1'b0, 1'b0, 2);
    load(32'h0000_3002, 3'd6, 1, 32'h1122_3344, 32'h0000_3000, 32'h1122_3344, 1'b0, 1'b1, 1'b0, 3);

    // Reset during the second waitrequest cycle of an LW abandons the read.
    @(negedge clk);
    req_valid        = 1'b1;
    req_addr         = 32'h0000_5000;
    req_type         = 3'd4;
    data_waitrequest = 1'b1;
    data_readdata    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_bus_read_1", {31'd0, data_read}, 32'd1);
    @(negedge clk);
    chk("mid_bus_read_2", {31'd0, data_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_data_read", {31'd0, data_read}, 32'd0);
    chk("abort_req_ready_in_reset", {31'd0, req_ready}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_data_address", data_address, 32'd0);
    chk("abort_resp_data", resp_data, 32'd0);
    chk("abort_resp_merge", {31'd0, resp_merge}, 32'd0);
    chk("abort_byte_offset", {30'd0, resp_byte_offset}, 32'd0);
    @(negedge clk);
    reset            = 1'b0;
    data_waitrequest = 1'b0;
    #1;
    chk("abort_req_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);

`ifdef LOAD_FETCH_TIMEOUT_EN
    begin
      exp_t e;
      @(negedge clk);
      chk("to_req_ready", {31'd0, req_ready}, 32'd1);
      req_valid        = 1'b1;
      req_addr         = 32'h0000_6000;
      req_type         = 3'd4;
      data_waitrequest = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.data  = 32'd0;
      e.off   = 2'b00;
      e.lwl   = 1'b0;
      e.merge = 1'b0;
      e.err   = 1'b1;
      e.at    = cyc + 5 - 1;
      sb.push_back(e);
      for (int i = 0; i < TB_TIMEOUT; i++) begin
        @(negedge clk);
        chk("to_data_read_stall", {31'd0, data_read}, 32'd1);
      end
      @(negedge clk);
      chk("to_data_read_dropped", {31'd0, data_read}, 32'd0);
      @(negedge clk);
      chk("to_data_read_after", {31'd0, data_read}, 32'd0);
      data_waitrequest = 1'b0;
    end
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
